// File: rtl/frame_scheduler.sv
// Double-buffered frame scheduler: starts renders on scene changes and swaps
// the display buffer on vsync once the rasterizer reports the frame drawn.
module frame_scheduler #(
    parameter int VSYNC_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_pulse,
    input  logic       obj_change,
    input  logic       raster_done,
    output logic       frame_start,
    output logic       draw_buf,
    output logic       disp_buf,
    output logic       busy,
    output logic       swap_pending,
    output logic [7:0] frame_count,
    output logic [7:0] overrun_count
);

    typedef enum logic [2:0] {IDLE, START, RENDER, WAIT_VS, SWAP} state_t;

    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic       done_q, done_d;
    logic [3:0] vs_cnt_q, vs_cnt_d;
    logic       disp_buf_q, disp_buf_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic [7:0] overrun_q, overrun_d;
    logic       frame_start_q, frame_start_d;

    logic want_frame;
    logic vs_ready;

    assign want_frame = pending_q | obj_change;
    assign vs_ready   = vsync_pulse && (({1'b0, vs_cnt_q} + 5'd1) >= 5'(VSYNC_DIV));

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        done_d        = raster_done;
        vs_cnt_d      = vs_cnt_q;
        disp_buf_d    = disp_buf_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        frame_start_d = (state_q == START);

        // A new request in the same cycle as START must survive the clear.
        if (obj_change)
            pending_d = 1'b1;
        else if (state_q == START)
            pending_d = 1'b0;

        if (state_q == SWAP)
            vs_cnt_d = 4'd0;
        else if (vsync_pulse && vs_cnt_q != 4'd15)
            vs_cnt_d = vs_cnt_q + 4'd1;

        if (vsync_pulse && (state_q == START || state_q == RENDER) && overrun_q != 8'd255)
            overrun_d = overrun_q + 8'd1;

        case (state_q)
            IDLE:    if (want_frame) state_d = START;
            START:   state_d = RENDER;
            // Only a fresh edge counts; a level left over from the last frame is stale.
            RENDER:  if (raster_done && !done_q) state_d = WAIT_VS;
            WAIT_VS: if (vs_ready) state_d = SWAP;
            SWAP: begin
                disp_buf_d    = ~disp_buf_q;
                frame_count_d = frame_count_q + 8'd1;
                state_d       = want_frame ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            done_q        <= 1'b0;
            vs_cnt_q      <= 4'd0;
            disp_buf_q    <= 1'b0;
            frame_count_q <= 8'd0;
            overrun_q     <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            done_q        <= done_d;
            vs_cnt_q      <= vs_cnt_d;
            disp_buf_q    <= disp_buf_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start   = frame_start_q;
    assign disp_buf      = disp_buf_q;
    assign draw_buf      = ~disp_buf_q;
    assign busy          = (state_q != IDLE);
    assign swap_pending  = (state_q == WAIT_VS);
    assign frame_count   = frame_count_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: two instances (divider 1 and 3) share directed
// stimulus and are checked every cycle against a phase-level reference model.
module tb_frame_scheduler;

    logic clk, rst, vsync_pulse, obj_change, raster_done;
    logic       fs1, draw1, disp1, busy1, sp1;
    logic [7:0] fc1, ov1;
    logic       fs3, draw3, disp3, busy3, sp3;
    logic [7:0] fc3, ov3;

    int n_cmp = 0;
    int n_bad = 0;

    frame_scheduler dut1 (
        .clk(clk), .rst(rst), .vsync_pulse(vsync_pulse), .obj_change(obj_change),
        .raster_done(raster_done), .frame_start(fs1), .draw_buf(draw1), .disp_buf(disp1),
        .busy(busy1), .swap_pending(sp1), .frame_count(fc1), .overrun_count(ov1)
    );

    frame_scheduler #(.VSYNC_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .vsync_pulse(vsync_pulse), .obj_change(obj_change),
        .raster_done(raster_done), .frame_start(fs3), .draw_buf(draw3), .disp_buf(disp3),
        .busy(busy3), .swap_pending(sp3), .frame_count(fc3), .overrun_count(ov3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the frame's life cycle as a phase plus plain counters.
    localparam int P_IDLE = 0, P_START = 1, P_RENDER = 2, P_WAIT = 3, P_SWAP = 4;

    typedef struct {
        int ph;
        bit pend;
        bit rd_prev;
        int vs;
        int disp;
        int frames;
        int over;
        bit fs;
    } mdl_t;

    mdl_t m1, m3;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.ph = P_IDLE; r.pend = 0; r.rd_prev = 0; r.vs = 0;
        r.disp = 0; r.frames = 0; r.over = 0; r.fs = 0;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t m, int div, bit vs, bit obj, bit rd);
        mdl_t n;
        bit want;
        n = m;
        want = m.pend || obj;
        n.fs = (m.ph == P_START);
        if (vs && (m.ph == P_START || m.ph == P_RENDER))
            n.over = (m.over >= 255) ? 255 : m.over + 1;
        if (m.ph == P_SWAP) n.vs = 0;
        else if (vs) n.vs = (m.vs >= 15) ? 15 : m.vs + 1;
        if (m.ph == P_IDLE && want) n.ph = P_START;
        else if (m.ph == P_START) n.ph = P_RENDER;
        else if (m.ph == P_RENDER && rd && !m.rd_prev) n.ph = P_WAIT;
        else if (m.ph == P_WAIT && vs && m.vs + 1 >= div) n.ph = P_SWAP;
        else if (m.ph == P_SWAP) begin
            n.disp = 1 - m.disp;
            n.frames = (m.frames + 1) % 256;
            n.ph = want ? P_START : P_IDLE;
        end
        n.pend = obj ? 1'b1 : ((m.ph == P_START) ? 1'b0 : m.pend);
        n.rd_prev = rd;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1 = mdl_reset();
            m3 = mdl_reset();
        end else begin
            m1 = step(m1, 1, vsync_pulse, obj_change, raster_done);
            m3 = step(m3, 3, vsync_pulse, obj_change, raster_done);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("d1.frame_start",   32'(fs1),   32'(m1.fs));
        check("d1.disp_buf",      32'(disp1), 32'(m1.disp));
        check("d1.draw_buf",      32'(draw1), 32'(1 - m1.disp));
        check("d1.busy",          32'(busy1), 32'(m1.ph != P_IDLE));
        check("d1.swap_pending",  32'(sp1),   32'(m1.ph == P_WAIT));
        check("d1.frame_count",   32'(fc1),   32'(m1.frames));
        check("d1.overrun_count", 32'(ov1),   32'(m1.over));
        check("d3.frame_start",   32'(fs3),   32'(m3.fs));
        check("d3.disp_buf",      32'(disp3), 32'(m3.disp));
        check("d3.draw_buf",      32'(draw3), 32'(1 - m3.disp));
        check("d3.busy",          32'(busy3), 32'(m3.ph != P_IDLE));
        check("d3.swap_pending",  32'(sp3),   32'(m3.ph == P_WAIT));
        check("d3.frame_count",   32'(fc3),   32'(m3.frames));
        check("d3.overrun_count", 32'(ov3),   32'(m3.over));
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_obj();
        obj_change = 1'b1; tick(1); obj_change = 1'b0;
    endtask

    task automatic pulse_vs();
        vsync_pulse = 1'b1; tick(1); vsync_pulse = 1'b0;
    endtask

    task automatic do_reset();
        vsync_pulse = 1'b0; obj_change = 1'b0; raster_done = 1'b0;
        rst = 1'b0;
        #1;
        check("rst.disp_buf", 32'(disp1), 0);
        check("rst.draw_buf", 32'(draw1), 1);
        check("rst.busy", 32'(busy1), 0);
        check("rst.frame_count", 32'(fc1), 0);
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; vsync_pulse = 1'b0; obj_change = 1'b0; raster_done = 1'b0;
        #1;

        // Basic frame with latency pins for frame_start and the buffer swap.
        do_reset();
        pulse_obj();
        check("lat.fs_n+1", 32'(fs1), 0);
        tick(1);
        check("lat.fs_n+2", 32'(fs1), 1);
        tick(1);
        check("lat.fs_n+3", 32'(fs1), 0);
        tick(17);
        raster_done = 1'b1;
        tick(10);
        pulse_vs();
        check("lat.disp_m+1", 32'(disp1), 0);
        tick(1);
        check("basic.disp_buf", 32'(disp1), 1);
        check("basic.draw_buf", 32'(draw1), 0);
        check("basic.frame_count", 32'(fc1), 1);
        check("basic.idle", 32'(busy1), 0);
        check("basic.div3_waiting", 32'(sp3), 1);
        raster_done = 1'b0;
        tick(3);

        // Stale raster_done level on entry to RENDER.
        do_reset();
        raster_done = 1'b1;
        pulse_obj();
        tick(5);
        check("stale.busy", 32'(busy1), 1);
        check("stale.no_wait", 32'(sp1), 0);
        raster_done = 1'b0;
        tick(2);
        check("stale.still_render", 32'(sp1), 0);
        raster_done = 1'b1;
        tick(2);
        check("stale.wait_vs", 32'(sp1), 1);
        pulse_vs();
        tick(3);
        check("stale.frame_count", 32'(fc1), 1);

        // Overruns: vsyncs while rendering.
        do_reset();
        pulse_obj();
        tick(2);
        repeat (3) begin
            pulse_vs();
            tick(2);
        end
        check("ovr.count1", 32'(ov1), 3);
        check("ovr.count3", 32'(ov3), 3);
        check("ovr.no_swap", 32'(fc1), 0);
        raster_done = 1'b1;
        tick(2);
        pulse_vs();
        tick(3);
        check("ovr.swap", 32'(fc1), 1);
        check("ovr.count_after", 32'(ov1), 3);
        check("ovr.div3_swap", 32'(fc3), 1);

        // Divider of 3: swap on the third vsync since the last swap.
        do_reset();
        pulse_obj();
        tick(2);
        raster_done = 1'b1;
        tick(2);
        pulse_vs();
        tick(2);
        check("div.vs1_fc", 32'(fc3), 0);
        check("div.vs1_wait", 32'(sp3), 1);
        pulse_vs();
        tick(2);
        check("div.vs2_fc", 32'(fc3), 0);
        pulse_vs();
        check("div.vs3_disp_m+1", 32'(disp3), 0);
        tick(1);
        check("div.vs3_disp", 32'(disp3), 1);
        check("div.vs3_fc", 32'(fc3), 1);
        raster_done = 1'b0;
        tick(3);

        // Back-to-back: request during WAIT_VS is served right after SWAP.
        do_reset();
        pulse_obj();
        tick(2);
        raster_done = 1'b1;
        tick(2);
        pulse_obj();
        tick(2);
        check("b2b.still_wait", 32'(sp1), 1);
        pulse_vs();
        check("b2b.swap_busy", 32'(busy1), 1);
        check("b2b.swap_not_wait", 32'(sp1), 0);
        tick(1);
        check("b2b.start_fs", 32'(fs1), 0);
        check("b2b.disp", 32'(disp1), 1);
        tick(1);
        check("b2b.fs", 32'(fs1), 1);
        tick(1);
        check("b2b.fs_end", 32'(fs1), 0);
        check("b2b.busy", 32'(busy1), 1);
        raster_done = 1'b0;
        tick(5);

        // Reset while waiting for vsync aborts the swap.
        do_reset();
        pulse_obj();
        tick(2);
        raster_done = 1'b1;
        tick(2);
        check("rstw.wait", 32'(sp1), 1);
        rst = 1'b0;
        #1;
        check("rstw.busy", 32'(busy1), 0);
        check("rstw.sp", 32'(sp1), 0);
        check("rstw.disp", 32'(disp1), 0);
        check("rstw.draw", 32'(draw1), 1);
        check("rstw.fs", 32'(fs1), 0);
        tick(2);
        rst = 1'b1;
        pulse_vs();
        tick(3);
        check("rstw.no_swap", 32'(fc1), 0);
        check("rstw.idle", 32'(busy1), 0);
        check("rstw.no_fs", 32'(fs1), 0);
        raster_done = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
